// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle between the control FSM (master) and the
// multi-cycle ALU (slave). The request side is start/op/a/b; the response side is
// busy/done plus the registered result and flags.
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;
  logic             err;

  modport master (
    output start, op, a, b,
    input  busy, done, result, zero, ovf, err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, zero, ovf, err
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU. Single-step logic/arith ops finish in one cycle, shifts
// move one bit per cycle, and the optional multiplier is a WIDTH-cycle shift-add.
// Result and flags are registered and only change on the cycle entering DONE.
// Build option: define ALU_MC_MUL_EN to make opcode 1100 an iterative multiply;
// without it 1100 is reported as an illegal opcode.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  alu_mc_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_MUL   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
`ifdef ALU_MC_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1100;
`endif

  // shift kind kept from the low opcode bits: 00 sll, 01 srl, 10 sra
  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRA = 2'b10;

  logic [1:0]       state_reg,  state_next;
  logic [SHW-1:0]   cnt_reg,    cnt_next;
  logic [1:0]       shop_reg,   shop_next;
  logic [WIDTH-1:0] work_reg,   work_next;   // shift operand, or multiplier bits
  logic [WIDTH-1:0] result_reg, result_next;
  logic             zero_reg,   zero_next;
  logic             ovf_reg,    ovf_next;
  logic             err_reg,    err_next;
`ifdef ALU_MC_MUL_EN
  logic [WIDTH-1:0] acc_reg,    acc_next;    // running partial product
  logic [WIDTH-1:0] mcand_reg,  mcand_next;  // multiplicand, shifted left each step
  logic [WIDTH-1:0] acc_sum;
`endif

  logic [WIDTH-1:0] ss_sum, ss_diff, ss_result;
  logic             ss_ovf, ss_err;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sh_left, sh_right, sh_step;
  logic             fin;
  logic [WIDTH-1:0] fin_value;
  logic             fin_ovf, fin_err;

  assign shamt = bus.b[SHW-1:0];

  // one-bit shift of the working operand; right shift fills with sign for sra
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shr
      assign sh_right[gi] = work_reg[gi+1];
    end
  endgenerate
  assign sh_right[WIDTH-1] = (shop_reg == SH_SRA) & work_reg[WIDTH-1];
  assign sh_left           = {work_reg[WIDTH-2:0], 1'b0};
  assign sh_step           = (shop_reg == SH_SLL) ? sh_left : sh_right;

  // single-cycle operations straight from the request operands
  always_comb begin
    ss_sum    = bus.a + bus.b;
    ss_diff   = bus.a - bus.b;
    ss_result = '0;
    ss_ovf    = 1'b0;
    ss_err    = 1'b0;
    case (bus.op)
      OP_AND:  ss_result = bus.a & bus.b;
      OP_OR:   ss_result = bus.a | bus.b;
      OP_XOR:  ss_result = bus.a ^ bus.b;
      OP_NOR:  ss_result = ~(bus.a | bus.b);
      OP_ADD: begin
        ss_result = ss_sum;
        ss_ovf    = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                    (ss_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        ss_result = ss_diff;
        ss_ovf    = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                    (ss_diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLT:  ss_result = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: ss_result = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      default: ss_err = 1'b1;
    endcase
  end

  // sequencing: accept, iterate, and load result/flags when entering DONE
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    shop_next   = shop_reg;
    work_next   = work_reg;
    result_next = result_reg;
    zero_next   = zero_reg;
    ovf_next    = ovf_reg;
    err_next    = err_reg;
    fin         = 1'b0;
    fin_value   = '0;
    fin_ovf     = 1'b0;
    fin_err     = 1'b0;
`ifdef ALU_MC_MUL_EN
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    acc_sum     = acc_reg + (work_reg[0] ? mcand_reg : '0);
`endif

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          case (bus.op)
            OP_SLL, OP_SRL, OP_SRA: begin
              if (shamt == '0) begin
                fin       = 1'b1;
                fin_value = bus.a;
              end else begin
                state_next = S_SHIFT;
                cnt_next   = shamt;
                work_next  = bus.a;
                shop_next  = bus.op[1:0];
              end
            end
`ifdef ALU_MC_MUL_EN
            OP_MUL: begin
              state_next = S_MUL;
              cnt_next   = '1;          // WIDTH-1: one step per multiplier bit
              work_next  = bus.b;
              mcand_next = bus.a;
              acc_next   = '0;
            end
`endif
            default: begin
              fin       = 1'b1;
              fin_value = ss_result;
              fin_ovf   = ss_ovf;
              fin_err   = ss_err;
            end
          endcase
        end else begin
          state_next = S_IDLE;
        end
      end
      S_SHIFT: begin
        work_next = sh_step;
        cnt_next  = cnt_reg - SHW'(1);
        if (cnt_reg == SHW'(1)) begin
          fin       = 1'b1;
          fin_value = sh_step;
        end
      end
`ifdef ALU_MC_MUL_EN
      S_MUL: begin
        acc_next   = acc_sum;
        mcand_next = {mcand_reg[WIDTH-2:0], 1'b0};
        work_next  = {1'b0, work_reg[WIDTH-1:1]};
        cnt_next   = cnt_reg - SHW'(1);
        if (cnt_reg == '0) begin
          fin       = 1'b1;
          fin_value = acc_sum;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase

    if (fin) begin
      state_next  = S_DONE;
      result_next = fin_value;
      zero_next   = (fin_value == '0);
      ovf_next    = fin_ovf;
      err_next    = fin_err;
    end
  end

  // state and output registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      shop_reg   <= '0;
      work_reg   <= '0;
      result_reg <= '0;
      zero_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      err_reg    <= 1'b0;
`ifdef ALU_MC_MUL_EN
      acc_reg    <= '0;
      mcand_reg  <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      shop_reg   <= shop_next;
      work_reg   <= work_next;
      result_reg <= result_next;
      zero_reg   <= zero_next;
      ovf_reg    <= ovf_next;
      err_reg    <= err_next;
`ifdef ALU_MC_MUL_EN
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
`endif
    end
  end

  assign bus.busy   = (state_reg == S_SHIFT) || (state_reg == S_MUL);
  assign bus.done   = (state_reg == S_DONE);
  assign bus.result = result_reg;
  assign bus.zero   = zero_reg;
  assign bus.ovf    = ovf_reg;
  assign bus.err    = err_reg;

endmodule
